// File: rtl/rv_wb_arbiter.sv
// rtl/rv_wb_arbiter.sv - register file write-port arbiter for ALU results and queued load returns
//
// Purpose:
//   Shares the single register file write port between ALU results (never
//   stalled, highest priority) and load returns (buffered in a small FIFO and
//   drained into slots the ALU leaves free). A per-register busy scoreboard
//   tracks issued loads that have not yet written back and raises o_hazard
//   for the issue stage.
//
// Optional feature (macro RV_WB_STATS_EN):
//   Adds o_conflict_cnt, a saturating count of cycles in which the ALU takes
//   the port while the load FIFO holds at least one entry.
//
// Ports:
//   i_clk, i_reset_n          clock, synchronous active-low reset
//   i_alu_valid/rd/data       ALU write-back request
//   i_ld_valid/rd/data        load return; o_ld_ready accepts it
//   i_ld_issue, i_ld_issue_rd load issued to the bus (sets busy bit)
//   i_chk_rs1/rs2/rd          operands of the instruction in issue
//   o_hazard                  issue must stall
//   o_rd/o_write/o_data       registered register file write port
//   o_idle                    FIFO empty and no busy bits set
//   o_conflict_cnt            (RV_WB_STATS_EN only) conflict cycle counter

module rv_wb_arbiter #(
    parameter int LD_FIFO_DEPTH = 2,
    parameter int STAT_W        = 16
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_alu_valid,
    input  logic [4:0]  i_alu_rd,
    input  logic [31:0] i_alu_data,
    input  logic        i_ld_valid,
    input  logic [4:0]  i_ld_rd,
    input  logic [31:0] i_ld_data,
    output logic        o_ld_ready,
    input  logic        i_ld_issue,
    input  logic [4:0]  i_ld_issue_rd,
    input  logic [4:0]  i_chk_rs1,
    input  logic [4:0]  i_chk_rs2,
    input  logic [4:0]  i_chk_rd,
    output logic        o_hazard,
    output logic [4:0]  o_rd,
    output logic        o_write,
    output logic [31:0] o_data,
    output logic        o_idle
`ifdef RV_WB_STATS_EN
    ,
    output logic [STAT_W-1:0] o_conflict_cnt
`endif
);

    localparam int PTR_W = (LD_FIFO_DEPTH > 1) ? $clog2(LD_FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(LD_FIFO_DEPTH);

    // Load-return FIFO storage (no reset needed: only read when count > 0)
    logic [4:0]  fifo_rd_q   [LD_FIFO_DEPTH];
    logic [31:0] fifo_data_q [LD_FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [31:1] busy_q, busy_d;

    logic        write_q, write_d;
    logic [4:0]  wr_rd_q, wr_rd_d;
    logic [31:0] wr_data_q, wr_data_d;

    logic        push;
    logic        pop;
    logic        alu_take;
    logic        fifo_nonempty;
    logic [4:0]  head_rd;
    logic [31:0] head_data;
    logic [31:0] busy_vec;

    assign fifo_nonempty = (count_q != '0);
    assign head_rd       = fifo_rd_q[rd_ptr_q];
    assign head_data     = fifo_data_q[rd_ptr_q];

    // Ready depends only on the registered count, so a pop in the same cycle
    // is not anticipated and there is no path from i_ld_valid.
    assign o_ld_ready = (count_q < DEPTH_C);
    assign push       = i_ld_valid & o_ld_ready;

    // ALU writes to x0 are dropped and leave the slot to the FIFO.
    assign alu_take = i_alu_valid & (i_alu_rd != 5'd0);
    // Pop looks at the registered count, so a load pushed this cycle cannot
    // be selected until the next one.
    assign pop      = ~alu_take & fifo_nonempty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Write-port selection; the result is registered onto o_rd/o_write/o_data.
    always_comb begin
        write_d   = 1'b0;
        wr_rd_d   = 5'd0;
        wr_data_d = 32'd0;
        if (alu_take) begin
            write_d   = 1'b1;
            wr_rd_d   = i_alu_rd;
            wr_data_d = i_alu_data;
        end else if (pop && (head_rd != 5'd0)) begin
            write_d   = 1'b1;
            wr_rd_d   = head_rd;
            wr_data_d = head_data;
        end
    end

    // Scoreboard: clear first, then set, so a new issue to the same register
    // as the entry being written keeps the bit (newer load outstanding).
    always_comb begin
        busy_d = busy_q;
        if (pop && (head_rd != 5'd0)) begin
            busy_d[head_rd] = 1'b0;
        end
        if (i_ld_issue && (i_ld_issue_rd != 5'd0)) begin
            busy_d[i_ld_issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            busy_q    <= '0;
            write_q   <= 1'b0;
            wr_rd_q   <= 5'd0;
            wr_data_q <= 32'd0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            write_q   <= write_d;
            wr_rd_q   <= wr_rd_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_rd_q[wr_ptr_q]   <= i_ld_rd;
            fifo_data_q[wr_ptr_q] <= i_ld_data;
        end
    end

    // x0 never holds a pending load.
    assign busy_vec = {busy_q, 1'b0};
    // The rd term blocks a WAW reorder where an older load would overwrite a
    // younger ALU result.
    assign o_hazard = busy_vec[i_chk_rs1] | busy_vec[i_chk_rs2] | busy_vec[i_chk_rd];
    assign o_idle   = ~fifo_nonempty & (busy_q == '0);

    assign o_write = write_q;
    assign o_rd    = wr_rd_q;
    assign o_data  = wr_data_q;

`ifdef RV_WB_STATS_EN
    logic [STAT_W-1:0] conflict_cnt_q, conflict_cnt_d;

    always_comb begin
        conflict_cnt_d = conflict_cnt_q;
        if (alu_take && fifo_nonempty && (conflict_cnt_q != '1)) begin
            conflict_cnt_d = conflict_cnt_q + STAT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            conflict_cnt_q <= '0;
        end else begin
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign o_conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_rv_wb_arbiter.sv
// tb/tb_rv_wb_arbiter.sv - self-checking bench for rv_wb_arbiter

module tb_rv_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        ld_issue;
    logic [4:0]  ld_issue_rd;
    logic [4:0]  chk_rs1;
    logic [4:0]  chk_rs2;
    logic [4:0]  chk_rd;
    logic        hazard;
    logic [4:0]  o_rd;
    logic        o_write;
    logic [31:0] o_data;
    logic        idle;
`ifdef RV_WB_STATS_EN
    logic [15:0] conflict_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    logic [36:0] ld_q[$];
    logic        alu_exp_v = 1'b0;
    logic [4:0]  alu_exp_rd = 5'd0;
    logic [31:0] alu_exp_data = 32'd0;
    bit          mon_en = 1'b0;

    rv_wb_arbiter #(.LD_FIFO_DEPTH(2), .STAT_W(16)) dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_alu_valid   (alu_valid),
        .i_alu_rd      (alu_rd),
        .i_alu_data    (alu_data),
        .i_ld_valid    (ld_valid),
        .i_ld_rd       (ld_rd),
        .i_ld_data     (ld_data),
        .o_ld_ready    (ld_ready),
        .i_ld_issue    (ld_issue),
        .i_ld_issue_rd (ld_issue_rd),
        .i_chk_rs1     (chk_rs1),
        .i_chk_rs2     (chk_rs2),
        .i_chk_rd      (chk_rd),
        .o_hazard      (hazard),
        .o_rd          (o_rd),
        .o_write       (o_write),
        .o_data        (o_data),
        .o_idle        (idle)
`ifdef RV_WB_STATS_EN
        ,
        .o_conflict_cnt(conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Scoreboard producer: an ALU request must appear on the port next cycle;
    // accepted loads to a nonzero rd are expected later, in arrival order.
    always @(posedge clk) begin
        if (!rst_n) begin
            alu_exp_v <= 1'b0;
            ld_q.delete();
        end else begin
            alu_exp_v    <= alu_valid && (alu_rd != 5'd0);
            alu_exp_rd   <= alu_rd;
            alu_exp_data <= alu_data;
            if (ld_valid && ld_ready && (ld_rd != 5'd0)) begin
                ld_q.push_back({ld_rd, ld_data});
            end
        end
    end

    // Scoreboard consumer.
    always @(negedge clk) begin
        logic [36:0] exp;
        if (mon_en) begin
            if (alu_exp_v) begin
                checks++;
                if (o_write !== 1'b1 || o_rd !== alu_exp_rd || o_data !== alu_exp_data) begin
                    failures++;
                    $display("FAIL sb_alu got write=%b rd=%0d data=%h exp rd=%0d data=%h",
                             o_write, o_rd, o_data, alu_exp_rd, alu_exp_data);
                end
            end else if (o_write !== 1'b0) begin
                checks++;
                if (ld_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected_write got write=%b rd=%0d data=%h exp no write",
                             o_write, o_rd, o_data);
                end else begin
                    exp = ld_q.pop_front();
                    if (o_write !== 1'b1 || {o_rd, o_data} !== exp) begin
                        failures++;
                        $display("FAIL sb_load got write=%b rd=%0d data=%h exp rd=%0d data=%h",
                                 o_write, o_rd, o_data, exp[36:32], exp[31:0]);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
        ld_valid = 1'b0; ld_rd = 5'd0; ld_data = 32'd0;
        ld_issue = 1'b0; ld_issue_rd = 5'd0;
        chk_rs1 = 5'd0; chk_rs2 = 5'd0; chk_rd = 5'd0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        mon_en = 1'b1;
        checks++;
        if (o_write !== 1'b0 || o_rd !== 5'd0 || o_data !== 32'd0) begin
            failures++;
            $display("FAIL reset_port got write=%b rd=%0d data=%h exp 0/0/0", o_write, o_rd, o_data);
        end
        checks++;
        if (ld_ready !== 1'b1 || idle !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready_idle got ready=%b idle=%b exp 1/1", ld_ready, idle);
        end
        for (int i = 0; i < 32; i++) begin
            chk_rs1 = 5'(i); chk_rs2 = 5'(31 - i); chk_rd = 5'(i);
            #1;
            checks++;
            if (hazard !== 1'b0) begin
                failures++;
                $display("FAIL reset_hazard reg=%0d got=%b exp=0", i, hazard);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_alu();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234_5678;
        tick();
        alu_valid = 1'b0;
        checks++;
        if (o_write !== 1'b1 || o_rd !== 5'd5 || o_data !== 32'h1234_5678) begin
            failures++;
            $display("FAIL alu_rd5 got write=%b rd=%0d data=%h exp 1/5/12345678", o_write, o_rd, o_data);
        end
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD_BEEF;
        tick();
        alu_valid = 1'b0;
        checks++;
        if (o_write !== 1'b0) begin
            failures++;
            $display("FAIL alu_rd0 got write=%b exp=0", o_write);
        end
        for (int i = 1; i < 4; i++) begin
            alu_valid = 1'b1; alu_rd = 5'(i + 28); alu_data = 32'hA000_0000 + 32'(i);
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_load_hazard();
        ld_issue = 1'b1; ld_issue_rd = 5'd7;
        tick();
        ld_issue = 1'b0;
        chk_rs1 = 5'd7;
        #1;
        checks++;
        if (hazard !== 1'b1 || idle !== 1'b0) begin
            failures++;
            $display("FAIL ld_hazard_rs1 got hazard=%b idle=%b exp 1/0", hazard, idle);
        end
        chk_rs1 = 5'd0; chk_rs2 = 5'd7;
        #1;
        checks++;
        if (hazard !== 1'b1) begin
            failures++;
            $display("FAIL ld_hazard_rs2 got=%b exp=1", hazard);
        end
        chk_rs2 = 5'd0; chk_rd = 5'd7;
        #1;
        checks++;
        if (hazard !== 1'b1) begin
            failures++;
            $display("FAIL ld_hazard_rd got=%b exp=1", hazard);
        end
        chk_rd = 5'd0; chk_rs1 = 5'd7;
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'hCAFE_F00D;
        tick();
        ld_valid = 1'b0;
        checks++;
        if (o_write !== 1'b0) begin
            failures++;
            $display("FAIL ld_no_bypass got write=%b exp=0", o_write);
        end
        tick();
        checks++;
        if (o_write !== 1'b1 || o_rd !== 5'd7 || o_data !== 32'hCAFE_F00D) begin
            failures++;
            $display("FAIL ld_write got write=%b rd=%0d data=%h exp 1/7/cafef00d", o_write, o_rd, o_data);
        end
        tick();
        checks++;
        if (hazard !== 1'b0 || idle !== 1'b1) begin
            failures++;
            $display("FAIL ld_busy_clear got hazard=%b idle=%b exp 0/1", hazard, idle);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_fifo_full();
        // c0: first load enters an empty FIFO
        ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h0000_3333;
        tick();
        // c1..c4: ALU owns the port every cycle
        alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'h1010_0001;
        ld_rd = 5'd4; ld_data = 32'h0000_4444;
        tick();
        ld_rd = 5'd6; ld_data = 32'h0000_6666;
        for (int i = 0; i < 3; i++) begin
            alu_rd = 5'(11 + i); alu_data = 32'h1010_0002 + 32'(i);
            #1;
            checks++;
            if (ld_ready !== 1'b0) begin
                failures++;
                $display("FAIL full_ready cyc=%0d got=%b exp=0", i, ld_ready);
            end
            tick();
        end
        alu_valid = 1'b0;
        // c5: still full, head rd=3 drains
        checks++;
        if (ld_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_ready_drain got=%b exp=0", ld_ready);
        end
        tick();
        checks++;
        if (o_write !== 1'b1 || o_rd !== 5'd3 || o_data !== 32'h0000_3333) begin
            failures++;
            $display("FAIL drain_first got write=%b rd=%0d data=%h exp 1/3/00003333", o_write, o_rd, o_data);
        end
        // c6: room again, held-off return accepted
        checks++;
        if (ld_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_pop got=%b exp=1", ld_ready);
        end
        tick();
        ld_valid = 1'b0;
        checks++;
        if (o_write !== 1'b1 || o_rd !== 5'd4 || o_data !== 32'h0000_4444) begin
            failures++;
            $display("FAIL drain_second got write=%b rd=%0d data=%h exp 1/4/00004444", o_write, o_rd, o_data);
        end
        tick();
        checks++;
        if (o_write !== 1'b1 || o_rd !== 5'd6) begin
            failures++;
            $display("FAIL drain_third got write=%b rd=%0d exp 1/6", o_write, o_rd);
        end
`ifdef RV_WB_STATS_EN
        checks++;
        if (conflict_cnt !== 16'd4) begin
            failures++;
            $display("FAIL conflict_cnt got=%0d exp=4", conflict_cnt);
        end
`endif
        idle_inputs();
        tick();
    endtask

    task automatic test_set_clear_same_cycle();
        ld_issue = 1'b1; ld_issue_rd = 5'd9;
        tick();
        ld_issue = 1'b0;
        chk_rs1 = 5'd9;
        ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h0909_0001;
        tick();
        ld_valid = 1'b0;
        // FIFO write of rd=9 is selected while a new load to rd=9 issues
        ld_issue = 1'b1; ld_issue_rd = 5'd9;
        tick();
        ld_issue = 1'b0;
        checks++;
        if (o_write !== 1'b1 || o_rd !== 5'd9 || hazard !== 1'b1) begin
            failures++;
            $display("FAIL setclr_same got write=%b rd=%0d hazard=%b exp 1/9/1", o_write, o_rd, hazard);
        end
        tick(); tick();
        checks++;
        if (hazard !== 1'b1) begin
            failures++;
            $display("FAIL setclr_hold got=%b exp=1", hazard);
        end
        ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h0909_0002;
        tick();
        ld_valid = 1'b0;
        tick();
        checks++;
        if (o_write !== 1'b1 || o_data !== 32'h0909_0002) begin
            failures++;
            $display("FAIL setclr_second got write=%b data=%h exp 1/09090002", o_write, o_data);
        end
        tick();
        checks++;
        if (hazard !== 1'b0 || idle !== 1'b1) begin
            failures++;
            $display("FAIL setclr_clear got hazard=%b idle=%b exp 0/1", hazard, idle);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        ld_issue = 1'b1; ld_issue_rd = 5'd20;
        tick();
        ld_issue_rd = 5'd21;
        tick();
        ld_issue = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h0000_0011;
        ld_valid = 1'b1; ld_rd = 5'd20; ld_data = 32'h2020_2020;
        tick();
        alu_rd = 5'd2; alu_data = 32'h0000_0022;
        ld_rd = 5'd21; ld_data = 32'h2121_2121;
        tick();
        idle_inputs();
        checks++;
        if (ld_ready !== 1'b0 || idle !== 1'b0) begin
            failures++;
            $display("FAIL mid_prefill got ready=%b idle=%b exp 0/0", ld_ready, idle);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_rs1 = 5'd20; chk_rs2 = 5'd21;
        #1;
        checks++;
        if (o_write !== 1'b0 || idle !== 1'b1 || ld_ready !== 1'b1 || hazard !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got write=%b idle=%b ready=%b hazard=%b exp 0/1/1/0",
                     o_write, idle, ld_ready, hazard);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (o_write !== 1'b0) begin
                failures++;
                $display("FAIL mid_no_write cyc=%0d got=%b exp=0", i, o_write);
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        test_reset();
        test_alu();
        test_load_hazard();
        test_fifo_full();
        test_set_clear_same_cycle();
        test_reset_mid();
        tick(); tick();
        checks++;
        if (ld_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drained got=%0d pending exp=0", ld_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
